fifo_rd_ctrl: RTL and testbench

Read-side controller for the asynchronous FIFO: it owns the read pointer, the empty flag and a one-entry registered output stage in front of the dual-port FIFO RAM. It consumes the write pointer, Gray-coded and already synchronized into the read clock domain. It drives the RAM read address and consumes the RAM's combinational read data. It exports its own Gray read pointer for synchronization into the write domain, and presents data to the consumer through a valid/ready handshake.

---
 rtl/fifo_rd_ctrl.sv | 102 ++++++++++
 tb/tb_fifo_rd_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: read pointer, empty flag and registered output stage.
// Optional FIFO_RD_GRAY_CHECK_EN adds a sticky illegal-Gray-step detector on the synced write pointer.
module fifo_rd_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray_sync,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  ptr_err
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         rd_bin_q, rd_bin_d;
  logic [PW-1:0]         rd_gray_q, rd_gray_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [PW-1:0]         wr_bin;
  logic                  load;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    wr_bin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      wr_bin[i] = ^(wr_ptr_gray_sync >> i);
    end
  end

  assign empty = (rd_gray_q == wr_ptr_gray_sync);
  assign load  = !empty && (!rd_valid_q || rd_ready);

  // Output stage refills in the same cycle it is popped, so streaming has no bubble
  always_comb begin
    rd_bin_d   = rd_bin_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    if (load) begin
      rd_bin_d   = rd_bin_q + PW'(1);
      rd_data_d  = ram_data;
      rd_valid_d = 1'b1;
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end
    rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_bin_q   <= '0;
      rd_gray_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_bin_q   <= rd_bin_d;
      rd_gray_q  <= rd_gray_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef FIFO_RD_GRAY_CHECK_EN
  logic [PW-1:0] wr_gray_q;
  logic [PW-1:0] gray_diff;
  logic          ptr_err_q, ptr_err_d;

  // More than one changed bit between consecutive synced samples is an illegal Gray step
  always_comb begin
    gray_diff = wr_ptr_gray_sync ^ wr_gray_q;
    ptr_err_d = ptr_err_q | (|(gray_diff & (gray_diff - PW'(1))));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_gray_q <= '0;
      ptr_err_q <= 1'b0;
    end else begin
      wr_gray_q <= wr_ptr_gray_sync;
      ptr_err_q <= ptr_err_d;
    end
  end

  assign ptr_err = ptr_err_q;
`else
  assign ptr_err = 1'b0;
`endif

  assign rd_addr     = rd_bin_q[ADDR_WIDTH-1:0];
  assign rd_ptr_gray = rd_gray_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_level    = wr_bin - rd_bin_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: writes push expected words, a monitor checks every pop.
module tb_fifo_rd_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] wr_ptr_gray_sync;
  logic [7:0] ram_data;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr_gray;
  logic       empty;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] rd_level;
  logic       ptr_err;

  logic [7:0] mem [16];
  logic [4:0] wr_bin;
  logic [7:0] expq [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  fifo_rd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .wr_ptr_gray_sync (wr_ptr_gray_sync),
    .ram_data         (ram_data),
    .rd_addr          (rd_addr),
    .rd_ptr_gray      (rd_ptr_gray),
    .empty            (empty),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_level         (rd_level),
    .ptr_err          (ptr_err)
  );

  always #5 CLK = ~CLK;

  assign ram_data = mem[rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    mem[wr_bin[3:0]] = d;
    expq.push_back(d);
    wr_bin = wr_bin + 5'd1;
  endtask

  task automatic publish();
    wr_ptr_gray_sync = gray(wr_bin);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    rd_ready = 1'b0;
    wr_bin = '0;
    wr_ptr_gray_sync = '0;
    expq.delete();
    step();
    step();
    RST = 1'b0;
  endtask

  // Monitor: a word is consumed at the next edge whenever valid and ready are both high
  always @(negedge CLK) begin
    if (!RST && rd_valid && rd_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_pop", {24'd0, rd_data}, 32'hFFFF_FFFF);
      end else begin
        chk("pop_data", {24'd0, rd_data}, {24'd0, expq.pop_front()});
      end
    end
  end

  initial begin
    int pops;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset state
    do_reset();
    chk("rst_empty", empty, 1);
    chk("rst_valid", rd_valid, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_gray", rd_ptr_gray, 0);
    chk("rst_level", rd_level, 0);
    chk("rst_ptr_err", ptr_err, 0);

    // Single word, consumer stalled then accepts
    write_word(8'hA5);
    publish();
    chk("one_empty_pre", empty, 0);
    chk("one_level_pre", rd_level, 1);
    step();
    chk("one_valid", rd_valid, 1);
    chk("one_data", rd_data, 8'hA5);
    chk("one_addr", rd_addr, 1);
    chk("one_gray", rd_ptr_gray, 5'b00001);
    chk("one_empty", empty, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_valid", rd_valid, 1);
      chk("hold_data", rd_data, 8'hA5);
      chk("hold_gray", rd_ptr_gray, 5'b00001);
    end
    rd_ready = 1'b1;
    step();
    chk("one_popped", rd_valid, 0);
    rd_ready = 1'b0;

    // Sixteen-word burst at full throughput
    do_reset();
    for (int i = 0; i < 16; i++) write_word(8'(i));
    publish();
    chk("burst_wr_gray", wr_ptr_gray_sync, 5'b11000);
    chk("burst_level_pre", rd_level, 16);
    rd_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("burst_valid", rd_valid, 1);
      chk("burst_addr", rd_addr, 32'(i % 16));
    end
    chk("burst_gray", rd_ptr_gray, 5'b11000);
    chk("burst_empty", empty, 1);
    chk("burst_level", rd_level, 0);
    step();
    chk("burst_drained", rd_valid, 0);

    // Second lap: pointers wrap back to zero
    for (int i = 0; i < 16; i++) write_word(8'h10 + 8'(i));
    publish();
    chk("wrap_wr_gray", wr_ptr_gray_sync, 5'b00000);
    chk("wrap_level_pre", rd_level, 16);
    chk("wrap_empty_pre", empty, 0);
    for (int i = 1; i <= 16; i++) step();
    chk("wrap_gray", rd_ptr_gray, 5'b00000);
    chk("wrap_addr", rd_addr, 0);
    chk("wrap_empty", empty, 1);
    step();
    chk("wrap_drained", rd_valid, 0);
    rd_ready = 1'b0;

    // Full RAM, stalled consumer, then toggling ready
    do_reset();
    for (int i = 0; i < 16; i++) write_word(8'h40 + 8'(i));
    publish();
    chk("full_level_pre", rd_level, 16);
    step();
    chk("full_valid", rd_valid, 1);
    chk("full_data", rd_data, 8'h40);
    chk("full_level", rd_level, 15);
    step();
    step();
    chk("full_level_hold", rd_level, 15);
    pops = 0;
    for (int c = 0; c < 200 && (expq.size() != 0 || rd_valid); c++) begin
      rd_ready = (c % 2 == 0);
      if (rd_ready && rd_valid) pops++;
      step();
    end
    rd_ready = 1'b0;
    chk("toggle_pops", pops, 16);
    chk("toggle_left", expq.size(), 0);
    chk("toggle_empty", empty, 1);

    // Illegal Gray step on the synced write pointer
    do_reset();
    wr_ptr_gray_sync = 5'b00011;
    step();
`ifdef FIFO_RD_GRAY_CHECK_EN
    chk("gray_err_set", ptr_err, 1);
    for (int k = 0; k < 3; k++) begin
      wr_ptr_gray_sync = 5'b00010;
      step();
      chk("gray_err_sticky", ptr_err, 1);
    end
`else
    chk("gray_err_off", ptr_err, 0);
    step();
    chk("gray_err_off2", ptr_err, 0);
`endif
    do_reset();
    chk("gray_err_cleared", ptr_err, 0);
    chk("final_queue", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
